mdu_issue_ctrl: RTL and testbench

//  Pipeline-side initiator for the HI/LO multiply-divide unit. Sits in E stage: drives the unit's op code and start.

---
 rtl/mdu_issue_ctrl.sv | 101 ++++++++++
 tb/tb_mdu_issue_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue control for the HI/LO multiply-divide unit: forwards op codes, starts
// mult/div, stalls D while an op is in flight and cross-checks the unit's busy signal.
module mdu_issue_ctrl #(
    parameter int unsigned LAT_MUL = 5,
    parameter int unsigned LAT_DIV = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             e_valid,
    input  logic [3:0]       e_md_op,
    input  logic             d_uses_md,
    input  logic             hilo_busy,
    output logic [3:0]       hilo_op,
    output logic             hilo_start,
    output logic             stall,
    output logic             md_pending,
    output logic             proto_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned LAT_MAX = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
    localparam int unsigned CW      = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StRunMul, StRunDiv} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          idle;

    assign idle = (state == StIdle);

    always_comb begin
        hilo_op    = 4'hF;
        hilo_start = 1'b0;
        if (e_valid) begin
            case (e_md_op)
                4'd0, 4'd1: hilo_op = e_md_op;
                4'd2, 4'd3: begin
                    if (!req && idle) hilo_op = e_md_op;
                end
                4'd4, 4'd5, 4'd6, 4'd7: begin
                    if (!req && idle) begin
                        hilo_op    = e_md_op;
                        hilo_start = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Unit busy is ORed in so a misbehaving unit can never let an instruction slip past.
    assign stall = d_uses_md & (hilo_start | md_pending | hilo_busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            cnt        <= '0;
            md_pending <= 1'b0;
            proto_err  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (hilo_start) begin
                        // Ops 5 and 7 (bit 0 set) are the divides.
                        if (e_md_op[0]) begin
                            state      <= StRunDiv;
                            cnt        <= CW'(LAT_DIV);
                        end else begin
                            state      <= StRunMul;
                            cnt        <= CW'(LAT_MUL);
                        end
                        md_pending <= 1'b1;
                    end
                end
                StRunMul, StRunDiv: begin
                    if (cnt <= CW'(1)) begin
                        state      <= StIdle;
                        cnt        <= '0;
                        md_pending <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state      <= StIdle;
                    cnt        <= '0;
                    md_pending <= 1'b0;
                end
            endcase

            if (hilo_busy != md_pending) proto_err <= 1'b1;

            if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares; a CNT_W=4 copy checks stall_cnt saturation.
module tb_mdu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic        d_uses_md;
    logic        hilo_busy;
    logic [3:0]  hilo_op;
    logic        hilo_start;
    logic        stall;
    logic        md_pending;
    logic        proto_err;
    logic [15:0] stall_cnt;

    logic [3:0]  s_hilo_op;
    logic        s_hilo_start;
    logic        s_stall;
    logic        s_md_pending;
    logic        s_proto_err;
    logic [3:0]  s_stall_cnt;

    mdu_issue_ctrl #(.LAT_MUL(5), .LAT_DIV(10), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .e_valid    (e_valid),
        .e_md_op    (e_md_op),
        .d_uses_md  (d_uses_md),
        .hilo_busy  (hilo_busy),
        .hilo_op    (hilo_op),
        .hilo_start (hilo_start),
        .stall      (stall),
        .md_pending (md_pending),
        .proto_err  (proto_err),
        .stall_cnt  (stall_cnt)
    );

    mdu_issue_ctrl #(.LAT_MUL(5), .LAT_DIV(10), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .e_valid    (e_valid),
        .e_md_op    (e_md_op),
        .d_uses_md  (d_uses_md),
        .hilo_busy  (hilo_busy),
        .hilo_op    (s_hilo_op),
        .hilo_start (s_hilo_start),
        .stall      (s_stall),
        .md_pending (s_md_pending),
        .proto_err  (s_proto_err),
        .stall_cnt  (s_stall_cnt)
    );

    typedef struct packed {
        logic        chk;
        logic [3:0]  op;
        logic        start;
        logic        stall;
        logic        pend;
        logic        perr;
        logic [15:0] scnt;
        logic [3:0]  scnt4;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] m_scnt  = '0;
    logic [3:0]  m_scnt4 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.chk) begin
                cmp("hilo_op", 32'(hilo_op), 32'(mon_e.op));
                cmp("hilo_start", 32'(hilo_start), 32'(mon_e.start));
                cmp("stall", 32'(stall), 32'(mon_e.stall));
                cmp("md_pending", 32'(md_pending), 32'(mon_e.pend));
                cmp("proto_err", 32'(proto_err), 32'(mon_e.perr));
                cmp("stall_cnt", 32'(stall_cnt), 32'(mon_e.scnt));
                cmp("stall_cnt_w4", 32'(s_stall_cnt), 32'(mon_e.scnt4));
            end
        end
    end

    // One clock cycle: apply inputs, queue the expected outputs, advance the stall-count model.
    task automatic v(input logic rst, input logic r, input logic ev, input logic [3:0] op,
                     input logic dmd, input logic busy, input logic [3:0] x_op,
                     input logic x_start, input logic x_stall, input logic x_pend,
                     input logic x_perr);
        exp_t e;
        reset     = rst;
        req       = r;
        e_valid   = ev;
        e_md_op   = op;
        d_uses_md = dmd;
        hilo_busy = busy;
        e.chk   = !rst;
        e.op    = x_op;
        e.start = x_start;
        e.stall = x_stall;
        e.pend  = x_pend;
        e.perr  = x_perr;
        e.scnt  = m_scnt;
        e.scnt4 = m_scnt4;
        sb.push_back(e);
        if (rst) begin
            m_scnt  = '0;
            m_scnt4 = '0;
        end else if (x_stall) begin
            if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
            if (m_scnt4 != 4'hF) m_scnt4 = m_scnt4 + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        e_valid   = 1'b0;
        e_md_op   = 4'hF;
        d_uses_md = 1'b0;
        hilo_busy = 1'b0;
        @(posedge clk);
        #1;
        v(1, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        v(1, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        // Reset values
        v(0, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        // Forwarding while idle
        v(0, 1, 1, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0);
        v(0, 1, 1, 4'd3, 0, 0, 4'hF, 0, 0, 0, 0);
        v(0, 0, 1, 4'd3, 1, 0, 4'd3, 0, 0, 0, 0);
        v(0, 0, 1, 4'd8, 0, 0, 4'hF, 0, 0, 0, 0);
        // MULT with D-stage md instruction throughout: 6 stall cycles
        v(0, 0, 1, 4'd6, 1, 0, 4'd6, 1, 1, 0, 0);
        repeat (5) v(0, 0, 0, 4'hF, 1, 1, 4'hF, 0, 1, 1, 0);
        v(0, 0, 0, 4'hF, 1, 0, 4'hF, 0, 0, 0, 0);
        // DIVU suppressed by req, then issued
        v(0, 1, 1, 4'd5, 1, 0, 4'hF, 0, 0, 0, 0);
        v(0, 0, 1, 4'd5, 0, 0, 4'd5, 1, 0, 0, 0);
        v(0, 0, 1, 4'd2, 0, 1, 4'hF, 0, 0, 1, 0);
        v(0, 0, 1, 4'd1, 0, 1, 4'd1, 0, 0, 1, 0);
        v(0, 0, 1, 4'd7, 1, 1, 4'hF, 0, 1, 1, 0);
        repeat (7) v(0, 0, 0, 4'hF, 0, 1, 4'hF, 0, 0, 1, 0);
        v(0, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        // Reset mid-DIV at cnt=6
        v(0, 0, 1, 4'd7, 0, 0, 4'd7, 1, 0, 0, 0);
        repeat (4) v(0, 0, 0, 4'hF, 0, 1, 4'hF, 0, 0, 1, 0);
        v(1, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        v(1, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        v(0, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        v(0, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        // Unit drops busy one cycle early after MULTU
        v(0, 0, 1, 4'd4, 0, 0, 4'd4, 1, 0, 0, 0);
        repeat (4) v(0, 0, 0, 4'hF, 0, 1, 4'hF, 0, 0, 1, 0);
        v(0, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 1, 0);
        repeat (3) v(0, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 1);
        // Saturation: 20 stall cycles driven by busy alone
        v(1, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
        v(0, 0, 0, 4'hF, 1, 1, 4'hF, 0, 1, 0, 0);
        repeat (19) v(0, 0, 0, 4'hF, 1, 1, 4'hF, 0, 1, 0, 1);
        v(0, 0, 0, 4'hF, 0, 0, 4'hF, 0, 0, 0, 1);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
